// File: rtl/uart_pkg.sv
// Shared UART definitions: default line rates, parity codes, TX state encoding.
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 9600;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int BAUD_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    function automatic logic parity_bit(input logic [7:0] b, input int mode);
        return (mode == PAR_ODD) ? ~^b : ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: counts 0..BIT_PERIOD-1 while enabled, bit_tick on terminal count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BIT_PERIOD = DEF_CLK_FREQ / DEF_BAUD_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam logic [BAUD_CNT_W-1:0] TERM = BAUD_CNT_W'(BIT_PERIOD - 1);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    assign bit_tick = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, 8 data bits LSB-first, optional parity, one stop bit.
// One byte accepted per valid/ready handshake in IDLE; all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int BIT_PERIOD = CLK_FREQ / BAUD_RATE,
    parameter int PARITY     = PAR_NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_tx_state_t state_q;
    logic [7:0]     shift_q;
    logic [7:0]     byte_q;
    logic [3:0]     idx_q;
    logic           tx_q;
    logic           ready_q;
    logic           done_q;
    logic           bit_tick;

    // Counter is held cleared in IDLE so each frame starts on a full bit period.
    uart_baud_gen #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == ST_IDLE),
        .en       (state_q != ST_IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q <= tx_data;
                        byte_q  <= tx_data;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (idx_q == 4'd7) begin
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= parity_bit(byte_q, PARITY);
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            // Drive the next bit straight from shift_q[1] so tx stays registered.
                            tx_q    <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                            idx_q   <= idx_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = ~ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity) checked cycle-by-cycle against a frame model.
module tb_uart_tx;

    localparam int BP = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] tx;
    logic [2:0] tx_busy;
    logic [2:0] tx_done;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 3; p++) begin : g_dut
        uart_tx #(
            .CLK_FREQ (1000),
            .BAUD_RATE(100),
            .PARITY   (p)
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .tx_data (tx_data[p]),
            .tx_valid(tx_valid[p]),
            .tx_ready(tx_ready[p]),
            .tx      (tx[p]),
            .tx_busy (tx_busy[p]),
            .tx_done (tx_done[p])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame bit k of a byte: start, data LSB-first, parity (if any), stop.
    function automatic logic exp_bit(input logic [7:0] b, input int par, input int k);
        int ones;
        ones = $countones(b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && par == 2) return (ones % 2) == 1;
        if (k == 9 && par == 1) return (ones % 2) == 0;
        return 1'b1;
    endfunction

    function automatic int frame_len(input int par);
        return (par != 0) ? 11 * BP : 10 * BP;
    endfunction

    // Called at a negedge. Handshakes byte b on instance d, then checks every cycle of the frame.
    task automatic xfer(input int d, input logic [7:0] b, input bit hold, input logic [7:0] nxt,
                        input int pulse_t, input int reset_t, output int waited);
        int lim;
        tx_valid[d] = 1'b1;
        tx_data[d]  = b;
        waited      = 0;
        while (!tx_ready[d] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready[d]) begin
            chk("hs_timeout", 0, 1);
            tx_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) tx_valid[d] = 1'b0;
        tx_data[d] = nxt;
        lim = frame_len(d);
        for (int t = 0; t < lim; t++) begin
            chk("tx_bit", tx[d], exp_bit(b, d, t / BP));
            chk("busy_in_frame", tx_busy[d], 1);
            chk("ready_in_frame", tx_ready[d], 0);
            chk("done_in_frame", tx_done[d], 0);
            if (t == reset_t) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_tx", tx[d], 1);
                chk("rst_ready", tx_ready[d], 1);
                chk("rst_done", tx_done[d], 0);
                return;
            end
            if (pulse_t >= 0 && t == pulse_t) begin
                tx_valid[d] = 1'b1;
                tx_data[d]  = 8'h3C;
            end else if (pulse_t >= 0 && t == pulse_t + 1) begin
                tx_valid[d] = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_at_end", tx_done[d], 1);
        chk("ready_at_end", tx_ready[d], 1);
        chk("busy_at_end", tx_busy[d], 0);
        chk("tx_at_end", tx[d], 1);
    endtask

    task automatic idle_check(input int d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_tx", tx[d], 1);
            chk("idle_done", tx_done[d], 0);
            chk("idle_busy", tx_busy[d], 0);
        end
    endtask

    initial begin
        int w;
        int d;
        logic [7:0] b;

        reset    = 1'b1;
        tx_valid = '0;
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_tx", tx[i], 1);
            chk("reset_ready", tx_ready[i], 1);
            chk("reset_busy", tx_busy[i], 0);
            chk("reset_done", tx_done[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Single byte, no parity; done pulse lasts exactly one cycle.
        xfer(0, 8'hA5, 1'b0, 8'hA5, -1, -1, w);
        idle_check(0, 3);

        // Back-to-back with valid held: second start one cycle after done.
        xfer(0, 8'h00, 1'b1, 8'hFF, -1, -1, w);
        xfer(0, 8'hFF, 1'b0, 8'hFF, -1, -1, w);
        chk("b2b_gap", w, 0);
        idle_check(0, 3);

        // Parity modes on 0x07.
        xfer(2, 8'h07, 1'b0, 8'h07, -1, -1, w);
        idle_check(2, 2);
        xfer(1, 8'h07, 1'b0, 8'h07, -1, -1, w);
        idle_check(1, 2);

        // Valid pulse mid-DATA is ignored.
        xfer(0, 8'hC3, 1'b0, 8'hC3, 4 * BP + 5, -1, w);
        idle_check(0, 5);

        // Data changed after handshake does not affect frame.
        xfer(0, 8'h55, 1'b0, 8'hAA, -1, -1, w);
        idle_check(0, 2);

        // Reset during data bit 3, then a clean frame.
        xfer(0, 8'hF0, 1'b0, 8'hF0, -1, 4 * BP + 5, w);
        idle_check(0, 2);
        xfer(0, 8'h81, 1'b0, 8'h81, -1, -1, w);
        idle_check(0, 1);

        // Random bytes on random parity modes with random idle gaps.
        for (int i = 0; i < 10; i++) begin
            d = int'($urandom_range(0, 2));
            b = 8'($urandom);
            idle_check(d, int'($urandom_range(0, 4)));
            xfer(d, b, 1'b0, 8'($urandom), -1, -1, w);
        end
        idle_check(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
